// File: rtl/insight_hart_sink_arb.sv
// insight_hart_sink_arb: per-hart FIFOs merged round-robin onto one registered,
// hart-tagged output stream; lossless backpressure or drop-and-count when full.
// Ports: clock, reset_n (async, active low); in_valid/in_ready/in_data per hart
// (hart i at in_data[i*DATA_W +: DATA_W]); out_valid/out_ready/out_data/out_hart
// merged stream; drop_cnt saturating drop total, drop_clr synchronous clear.
module insight_hart_sink_arb #(
    parameter int NUM_HARTS    = 4,
    parameter int DATA_W       = 8,
    parameter int FIFO_DEPTH   = 4,
    parameter int DROP_ON_FULL = 0,
    parameter int CNT_W        = 16,
    localparam int HW = (NUM_HARTS > 1) ? $clog2(NUM_HARTS) : 1
) (
    input  logic                        clock,
    input  logic                        reset_n,
    input  logic [NUM_HARTS-1:0]        in_valid,
    output logic [NUM_HARTS-1:0]        in_ready,
    input  logic [NUM_HARTS*DATA_W-1:0] in_data,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [DATA_W-1:0]           out_data,
    output logic [HW-1:0]               out_hart,
    output logic [CNT_W-1:0]            drop_cnt,
    input  logic                        drop_clr
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int SW = CNT_W + 6;
    localparam logic [PW:0] PTR_ONE = (PW+1)'(1);

    logic [DATA_W-1:0]    mem [NUM_HARTS][FIFO_DEPTH];
    logic [PW:0]          wr_ptr [NUM_HARTS];
    logic [PW:0]          rd_ptr [NUM_HARTS];
    logic [NUM_HARTS-1:0] empty;
    logic [NUM_HARTS-1:0] full;
    logic [NUM_HARTS-1:0] push;
    logic [NUM_HARTS-1:0] drop;
    logic [NUM_HARTS-1:0] pop;
    logic [HW-1:0]        ptr;
    logic [HW-1:0]        gnt;
    logic [HW-1:0]        hi_g;
    logic [HW-1:0]        lo_g;
    logic                 hi_ok;
    logic                 lo_ok;
    logic                 load;
    logic [DATA_W-1:0]    head;
    logic [4:0]           ndrop;
    logic [SW-1:0]        cnt_sum;

    // Full when the pointers differ only in the wrap bit.
    always_comb begin
        empty = '0;
        full  = '0;
        for (int i = 0; i < NUM_HARTS; i++) begin
            empty[i] = (wr_ptr[i] == rd_ptr[i]);
            full[i]  = (wr_ptr[i][PW] != rd_ptr[i][PW]) &&
                       (wr_ptr[i][PW-1:0] == rd_ptr[i][PW-1:0]);
        end
    end

    assign in_ready = (DROP_ON_FULL != 0) ? {NUM_HARTS{1'b1}} : ~full;
    assign push     = in_valid & ~full;
    assign drop     = (DROP_ON_FULL != 0) ? (in_valid & full) : '0;

    // Round robin: lowest non-empty index >= ptr wins, else lowest overall.
    always_comb begin
        hi_g  = '0;
        lo_g  = '0;
        hi_ok = 1'b0;
        lo_ok = 1'b0;
        for (int i = NUM_HARTS - 1; i >= 0; i--) begin
            if (!empty[i]) begin
                lo_g  = HW'(i);
                lo_ok = 1'b1;
                if (HW'(i) >= ptr) begin
                    hi_g  = HW'(i);
                    hi_ok = 1'b1;
                end
            end
        end
    end

    assign gnt  = hi_ok ? hi_g : lo_g;
    assign load = (!out_valid || out_ready) && lo_ok;

    always_comb begin
        pop  = '0;
        head = '0;
        for (int i = 0; i < NUM_HARTS; i++) begin
            if (gnt == HW'(i)) begin
                pop[i] = load;
                head   = mem[i][rd_ptr[i][PW-1:0]];
            end
        end
    end

    always_comb begin
        ndrop = '0;
        for (int i = 0; i < NUM_HARTS; i++) begin
            ndrop = ndrop + 5'(drop[i]);
        end
        cnt_sum = SW'(drop_cnt) + SW'(ndrop);
    end

    always_ff @(posedge clock) begin
        for (int i = 0; i < NUM_HARTS; i++) begin
            if (push[i]) begin
                mem[i][wr_ptr[i][PW-1:0]] <= in_data[i*DATA_W +: DATA_W];
            end
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NUM_HARTS; i++) begin
                wr_ptr[i] <= '0;
                rd_ptr[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_HARTS; i++) begin
                if (push[i]) wr_ptr[i] <= wr_ptr[i] + PTR_ONE;
                if (pop[i])  rd_ptr[i] <= rd_ptr[i] + PTR_ONE;
            end
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_hart  <= '0;
            ptr       <= '0;
            drop_cnt  <= '0;
        end else begin
            if (load) begin
                out_valid <= 1'b1;
                out_data  <= head;
                out_hart  <= gnt;
                ptr       <= (gnt == HW'(NUM_HARTS - 1)) ? '0 : gnt + HW'(1);
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
            if (drop_clr) begin
                drop_cnt <= '0;
            end else if (cnt_sum > {6'b0, {CNT_W{1'b1}}}) begin
                drop_cnt <= '1;
            end else begin
                drop_cnt <= cnt_sum[CNT_W-1:0];
            end
        end
    end

endmodule

// File: doc/insight_hart_sink_arb.md
Name: insight_hart_sink_arb

Overview:
- Parametrised, multi-hart successor to the single-hart Insight ready/valid/sink channel.
- Collects trace/sink words from NUM_HARTS independent hart channels.
- Buffers each channel in its own FIFO and round-robin merges all channels onto one registered output stream tagged with the source hart.
- Sits between the per-hart Insight sources and the shared Insight sink/trace encoder.
- Offers either lossless backpressure or lossy drop-with-count on a full FIFO.

Parameters:
- NUM_HARTS, 4, number of input hart channels (1..16).
- DATA_W, 8, width of each sink word.
- FIFO_DEPTH, 4, entries per channel FIFO; power of two, >= 2.
- DROP_ON_FULL, 0, 0 = backpressure when full; 1 = always ready, drop and count when full.
- CNT_W, 16, width of the saturating drop counter.

Ports:
- clock, input, 1, single clock; all state on rising edge.
- reset_n, input, 1, asynchronous active-low reset.
- in_valid, input, NUM_HARTS, per-hart word valid.
- in_ready, output, NUM_HARTS, per-hart ready.
- in_data, input, NUM_HARTS*DATA_W, per-hart word; hart i occupies bits [i*DATA_W +: DATA_W].
- out_valid, output, 1, merged word valid.
- out_ready, input, 1, downstream ready.
- out_data, output, DATA_W, merged word.
- out_hart, output, max(1,clog2(NUM_HARTS)), source hart of out_data.
- drop_cnt, output, CNT_W, total words dropped, saturating.
- drop_clr, input, 1, synchronous clear of drop_cnt.

Behaviour:
- Reset (reset_n low, asynchronous):
  - All FIFOs empty.
  - out_valid=0, out_data=0, out_hart=0, drop_cnt=0.
  - Round-robin pointer=0.
  - in_ready = all ones in both modes, because FIFOs are empty.
  - Reset mid-operation discards all buffered and in-flight words with no partial output.
- Push:
  - Hart i push occurs when in_valid[i] && in_ready[i] at a rising edge.
  - Backpressure mode: in_ready[i] = !full[i]. It is derived from registered FIFO state only, with no combinational path from out_ready.
  - Drop mode: in_ready[i]=1 always.
  - Drop mode, in_valid[i] while full[i] (full evaluated before any same-cycle pop): the word is discarded, FIFO unchanged, drop_cnt increments.
- Drop counter:
  - Several harts dropping in the same cycle add their count (0..NUM_HARTS) in one cycle.
  - Saturates at 2^CNT_W-1, with no wrap.
  - drop_clr has priority over same-cycle increments: the result is 0.
  - In backpressure mode drop_cnt stays 0.
- FIFO:
  - Per-channel circular buffer using clog2(FIFO_DEPTH)+1-bit read/write pointers; wrap handled by the extra bit.
  - Simultaneous push and pop on a non-full FIFO keeps the occupancy unchanged.
  - Pop from an empty FIFO never occurs.
- Output stage:
  - Single register: out_valid, out_data, out_hart.
  - It loads when (!out_valid || out_ready) and at least one FIFO is non-empty.
  - On load, the arbiter grant pops the head of the granted FIFO.
  - If no FIFO is non-empty while out_ready consumes the current word, out_valid deasserts next cycle.
  - While out_valid && !out_ready: out_data and out_hart are held stable, with no pop.
- Arbiter:
  - Round-robin search starts at the pointer: the first non-empty FIFO at index >= ptr, wrapping modulo NUM_HARTS.
  - After a grant to hart g, ptr = (g+1) mod NUM_HARTS.
  - ptr is unchanged when there is no grant.
- Ordering and throughput:
  - Per-hart order is preserved. There is no ordering guarantee across harts beyond round-robin.
  - Latency: a word pushed at edge t into an idle block (all FIFOs empty, output empty) appears with out_valid=1 after edge t+1 (2-cycle minimum).
  - Sustained throughput is 1 word/cycle with out_ready held high.
- NUM_HARTS=1: the arbiter degenerates to a pass-through and out_hart is constant 0.

Test Plan:
- Reset then single word: hart 2 pushes 0xA5 at cycle 0, out_ready=1 -> out_valid=1, out_data=0xA5, out_hart=2 two edges later; out_valid=0 the following cycle.
- Fairness: all 4 harts continuously valid, out_ready=1 -> out_hart sequence 0,1,2,3,0,1,... with no gaps after the pipeline fills.
- Backpressure (DROP_ON_FULL=0, depth 4): out_ready=0, hart 1 pushes 6 words -> 1 word in the output register, 4 in the FIFO, in_ready[1]=0; the 6th word is stalled, not lost; releasing out_ready yields all 6 in order; drop_cnt=0.
- Drop mode (DROP_ON_FULL=1): same stimulus with 8 words -> 3 dropped (drop_cnt=3); the first 5 are delivered in order; drop_clr pulse -> drop_cnt=0.
- Saturation: CNT_W=4, drop mode, 3 harts dropping simultaneously for 6 cycles -> drop_cnt stops at 15; drop_clr coinciding with a drop -> 0.
- Async reset mid-stream: reset_n low while out_valid=1 and FIFOs partly full -> out_valid=0 immediately (not waiting for a clock edge), FIFOs empty after release; the first post-reset word appears with 2-cycle latency and ptr=0.
